// File: rtl/avst_tx_pkt_gen_if.sv
`default_nettype none
// ============================================================================
// Module : avst_tx_pkt_gen_if
// Brief  : 64-bit Avalon-ST bundle between the packet generator and the sink.
// Rev    : 1.0  initial release
// ============================================================================
interface avst_tx_pkt_gen_if;
   logic [63:0] data;
   logic        valid;
   logic        ready;
   logic        startofpacket;
   logic        endofpacket;
   logic [2:0]  empty;
   logic        error;

   modport master (
      output data, valid, startofpacket, endofpacket, empty, error,
      input  ready
   );

   modport slave (
      input  data, valid, startofpacket, endofpacket, empty, error,
      output ready
   );
endinterface
`default_nettype wire

// File: rtl/avst_tx_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module : avst_tx_pkt_gen
// Brief  : Avalon-ST Ethernet frame source with sequence numbers, gaps and
//          counters. Optional eop error injection under PKTGEN_ERR_INJECT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module avst_tx_pkt_gen #(
   parameter int          MAX_LEN   = 9600,
   parameter int          MIN_LEN   = 64,
   parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
   input  wire logic        clk_156_in_clk_clk,
   input  wire logic        rst_in_reset_reset_n,
   input  wire logic        start,
   input  wire logic        stop,
   input  wire logic [13:0] cfg_len,
   input  wire logic [31:0] cfg_num_pkts,
   input  wire logic [7:0]  cfg_gap,
   input  wire logic [47:0] cfg_dst_mac,
   input  wire logic [47:0] cfg_src_mac,
`ifdef PKTGEN_ERR_INJECT_EN
   input  wire logic [7:0]  cfg_err_every,
`endif
   avst_tx_pkt_gen_if.master tx_st_out,
   output logic             busy,
   output logic             done,
   output logic [31:0]      sent_pkts,
   output logic [31:0]      stall_cycles
);

   localparam logic [13:0] c_min_len  = 14'(MIN_LEN);
   localparam logic [13:0] c_max_len  = 14'(MAX_LEN);

   localparam logic [1:0]  c_st_idle  = 2'd0;
   localparam logic [1:0]  c_st_send  = 2'd1;
   localparam logic [1:0]  c_st_gap   = 2'd2;

   logic [1:0]  r_state;
   logic [1:0]  w_next_state;

   logic [47:0] r_dst;
   logic [47:0] r_src;
   logic [31:0] r_num;
   logic [7:0]  r_gap;
   logic [10:0] r_last_beat;
   logic [2:0]  r_eop_empty;
   logic [10:0] r_beat;
   logic [7:0]  r_gap_cnt;
   logic [15:0] r_seq;
   logic        r_stop_seen;
   logic [31:0] r_sent_pkts;
   logic [31:0] r_stall_cycles;
   logic        r_done;

   logic [13:0] w_len_clamped;
   logic [10:0] w_last_beat;
   logic        w_valid;
   logic        w_eop;
   logic        w_xfer;
   logic        w_eop_xfer;
   logic        w_run_over;
   logic        w_err;
   logic [3:0]  w_keep;

   always_comb begin
      w_len_clamped = cfg_len;
      if (cfg_len < c_min_len) begin
         w_len_clamped = c_min_len;
      end else if (cfg_len > c_max_len) begin
         w_len_clamped = c_max_len;
      end
   end

   // Index of the eop beat: ceil(L/8) - 1
   assign w_last_beat = w_len_clamped[13:3] + {10'd0, |w_len_clamped[2:0]} - 11'd1;

   assign w_valid    = (r_state == c_st_send);
   assign w_eop      = w_valid && (r_beat == r_last_beat);
   assign w_xfer     = w_valid && tx_st_out.ready;
   assign w_eop_xfer = w_xfer && w_eop;
   assign w_run_over = ((r_num != 32'd0) && ((r_sent_pkts + 32'd1) == r_num))
                       || r_stop_seen || stop;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk_156_in_clk_clk) begin
      if (!rst_in_reset_reset_n) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_idle: begin
            if (start) begin
               w_next_state = c_st_send;
            end
         end
         c_st_send: begin
            if (w_eop_xfer) begin
               if (w_run_over) begin
                  w_next_state = c_st_idle;
               end else if (r_gap != 8'd0) begin
                  w_next_state = c_st_gap;
               end else begin
                  w_next_state = c_st_send;
               end
            end
         end
         c_st_gap: begin
            if (stop) begin
               w_next_state = c_st_idle;
            end else if (r_gap_cnt == 8'd0) begin
               w_next_state = c_st_send;
            end
         end
         default: begin
            w_next_state = c_st_idle;
         end
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk_156_in_clk_clk) begin
      if (!rst_in_reset_reset_n) begin
         r_dst          <= '0;
         r_src          <= '0;
         r_num          <= '0;
         r_gap          <= '0;
         r_last_beat    <= '0;
         r_eop_empty    <= '0;
         r_beat         <= '0;
         r_gap_cnt      <= '0;
         r_seq          <= '0;
         r_stop_seen    <= 1'b0;
         r_sent_pkts    <= '0;
         r_stall_cycles <= '0;
         r_done         <= 1'b0;
      end else begin
         r_done <= (r_state != c_st_idle) && (w_next_state == c_st_idle);
         if (r_state == c_st_idle) begin
            if (start) begin
               r_dst          <= cfg_dst_mac;
               r_src          <= cfg_src_mac;
               r_num          <= cfg_num_pkts;
               r_gap          <= cfg_gap;
               r_last_beat    <= w_last_beat;
               r_eop_empty    <= 3'd0 - w_len_clamped[2:0];
               r_beat         <= '0;
               r_seq          <= '0;
               r_stop_seen    <= 1'b0;
               r_sent_pkts    <= '0;
               r_stall_cycles <= '0;
            end
         end else begin
            if (w_valid && !tx_st_out.ready && (r_stall_cycles != '1)) begin
               r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_xfer) begin
               r_beat <= w_eop ? 11'd0 : r_beat + 11'd1;
            end
            // A stop seen during a frame is remembered until that frame's eop
            if (w_eop_xfer) begin
               r_seq       <= r_seq + 16'd1;
               r_sent_pkts <= r_sent_pkts + 32'd1;
               r_stop_seen <= 1'b0;
               r_gap_cnt   <= r_gap - 8'd1;
            end else if (stop && (r_state == c_st_send)) begin
               r_stop_seen <= 1'b1;
            end
            if ((r_state == c_st_gap) && (r_gap_cnt != 8'd0)) begin
               r_gap_cnt <= r_gap_cnt - 8'd1;
            end
         end
      end
   end

`ifdef PKTGEN_ERR_INJECT_EN
   logic [7:0] r_err_every;
   logic [7:0] r_err_cnt;
   logic       w_err_hit;

   // r_err_cnt tracks (seq mod err_every), avoiding a divider
   assign w_err_hit = (r_err_every != 8'd0) && ((r_err_cnt + 8'd1) == r_err_every);

   always_ff @(posedge clk_156_in_clk_clk) begin
      if (!rst_in_reset_reset_n) begin
         r_err_every <= '0;
         r_err_cnt   <= '0;
      end else if ((r_state == c_st_idle) && start) begin
         r_err_every <= cfg_err_every;
         r_err_cnt   <= '0;
      end else if (w_eop_xfer) begin
         r_err_cnt <= w_err_hit ? 8'd0 : r_err_cnt + 8'd1;
      end
   end

   assign w_err = w_eop && w_err_hit;
`else
   assign w_err = 1'b0;
`endif

   // ---------------------------------------------------------------- outputs
   always_comb begin
      tx_st_out.valid         = w_valid;
      tx_st_out.startofpacket = w_valid && (r_beat == 11'd0);
      tx_st_out.endofpacket   = w_eop;
      tx_st_out.empty         = w_eop ? r_eop_empty : 3'd0;
      tx_st_out.error         = w_err;
      tx_st_out.data          = '0;
      w_keep                  = 4'd8 - {1'b0, r_eop_empty};
      if (w_valid) begin
         case (r_beat)
            11'd0:   tx_st_out.data = {r_dst, r_src[47:32]};
            11'd1:   tx_st_out.data = {r_src[31:0], ETHERTYPE, r_seq};
            default: begin
               // Payload byte j of beat b is (8b + j) mod 256
               for (int j = 0; j < 8; j++) begin
                  tx_st_out.data[63-8*j -: 8] = {r_beat[4:0], 3'(j)};
               end
            end
         endcase
         if (w_eop) begin
            for (int j = 0; j < 8; j++) begin
               if (4'(j) >= w_keep) begin
                  tx_st_out.data[63-8*j -: 8] = 8'd0;
               end
            end
         end
      end
      busy = (r_state != c_st_idle);
   end

   assign done         = r_done;
   assign sent_pkts    = r_sent_pkts;
   assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_avst_tx_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_avst_tx_pkt_gen
// Brief  : Directed, table-driven self-checking bench for avst_tx_pkt_gen.
// Rev    : 1.0  initial release
// ============================================================================
module tb_avst_tx_pkt_gen;

   localparam logic [47:0] c_dst = 48'h0011_2233_4455;
   localparam logic [47:0] c_src = 48'hA1B2_C3D4_E5F6;

   typedef struct {
      logic [13:0] len;
      logic [31:0] num;
      logic [7:0]  gap;
      bit          bp;
      int          stop_fr;
      logic [7:0]  err;
      int          exp_len;
      int          exp_beats;
      logic [2:0]  exp_empty;
      int          exp_frames;
      int          exp_stall;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        stop;
   logic [13:0] cfg_len;
   logic [31:0] cfg_num_pkts;
   logic [7:0]  cfg_gap;
   logic [47:0] cfg_dst_mac;
   logic [47:0] cfg_src_mac;
   logic [7:0]  err_every;
   logic        busy;
   logic        done;
   logic [31:0] sent_pkts;
   logic [31:0] stall_cycles;

   int checks = 0;
   int errors = 0;
   vec_t vecs[9];

   avst_tx_pkt_gen_if tx_st_out();

   avst_tx_pkt_gen dut (
      .clk_156_in_clk_clk   (clk),
      .rst_in_reset_reset_n (rst_n),
      .start                (start),
      .stop                 (stop),
      .cfg_len              (cfg_len),
      .cfg_num_pkts         (cfg_num_pkts),
      .cfg_gap              (cfg_gap),
      .cfg_dst_mac          (cfg_dst_mac),
      .cfg_src_mac          (cfg_src_mac),
`ifdef PKTGEN_ERR_INJECT_EN
      .cfg_err_every        (err_every),
`endif
      .tx_st_out            (tx_st_out),
      .busy                 (busy),
      .done                 (done),
      .sent_pkts            (sent_pkts),
      .stall_cycles         (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Frame viewed as a byte stream, then sliced into beats
   function automatic logic [63:0] exp_beat(input int b, input int len, input logic [15:0] seq);
      logic [127:0] hdr;
      logic [63:0]  r;
      logic [7:0]   byt;
      int           k;
      hdr = {c_dst, c_src, 16'h88B5, seq};
      r   = '0;
      for (int j = 0; j < 8; j++) begin
         k = 8 * b + j;
         if (k >= len)    byt = 8'd0;
         else if (k < 16) byt = hdr[127-8*k -: 8];
         else             byt = k[7:0];
         r[63-8*j -: 8] = byt;
      end
      return r;
   endfunction

   task automatic run_vec(input int idx, input vec_t tv);
      int   b, fr, gcnt;
      bit   gap_act, prev_stall, fin, exp_eop, exp_err;
      logic [63:0] pdata;
      logic        psop, peop;
      logic [2:0]  pempty;
      @(negedge clk);
      cfg_len      = tv.len;
      cfg_num_pkts = tv.num;
      cfg_gap      = tv.gap;
      cfg_dst_mac  = c_dst;
      cfg_src_mac  = c_src;
`ifdef PKTGEN_ERR_INJECT_EN
      err_every    = tv.err;
`else
      err_every    = 8'd0;
`endif
      start = 1'b1;
      tx_st_out.ready = 1'b1;
      b = 0; fr = 0; gcnt = 0; gap_act = 0; prev_stall = 0; fin = 0;
      pdata = '0; psop = 0; peop = 0; pempty = '0;
      for (int c = 0; c < 20000 && !fin; c++) begin
         @(negedge clk);
         // A second start while running must be ignored, new cfg included
         start = (c == 2);
         if (c == 2) begin
            cfg_len     = 14'd200;
            cfg_dst_mac = 48'd0;
         end
         stop = (tv.stop_fr != 0) && (fr == tv.stop_fr - 1) && (b == 3);
         tx_st_out.ready = tv.bp ? ((c % 3) == 0) : 1'b1;
         if (c == 0) chk($sformatf("v%0d valid_after_start", idx), tx_st_out.valid, 1'b1);
         if (prev_stall) begin
            chk($sformatf("v%0d hold_valid", idx), tx_st_out.valid, 1'b1);
            chk($sformatf("v%0d hold_data", idx), tx_st_out.data, pdata);
            chk($sformatf("v%0d hold_ctl", idx),
                {tx_st_out.startofpacket, tx_st_out.endofpacket, tx_st_out.empty},
                {psop, peop, pempty});
         end
         if (tx_st_out.valid) begin
            if (gap_act) begin
               chk($sformatf("v%0d gap_len f%0d", idx, fr), gcnt, tv.gap);
               gap_act = 0;
            end
            exp_eop = (b == tv.exp_beats - 1);
            exp_err = exp_eop && (err_every != 0) && (((fr + 1) % err_every) == 0);
            chk($sformatf("v%0d sop f%0d b%0d", idx, fr, b), tx_st_out.startofpacket, b == 0);
            chk($sformatf("v%0d eop f%0d b%0d", idx, fr, b), tx_st_out.endofpacket, exp_eop);
            chk($sformatf("v%0d empty f%0d b%0d", idx, fr, b), tx_st_out.empty,
                exp_eop ? tv.exp_empty : 3'd0);
            chk($sformatf("v%0d error f%0d b%0d", idx, fr, b), tx_st_out.error, exp_err);
            chk($sformatf("v%0d data f%0d b%0d", idx, fr, b), tx_st_out.data,
                exp_beat(b, tv.exp_len, fr[15:0]));
            if (tx_st_out.ready) begin
               if (exp_eop) begin
                  fr++;
                  b = 0;
                  gap_act = 1;
                  gcnt = 0;
               end else begin
                  b++;
               end
            end
         end else if (done) begin
            fin = 1;
         end else if (gap_act) begin
            gcnt++;
         end
         prev_stall = tx_st_out.valid && !tx_st_out.ready;
         pdata  = tx_st_out.data;
         psop   = tx_st_out.startofpacket;
         peop   = tx_st_out.endofpacket;
         pempty = tx_st_out.empty;
      end
      start = 1'b0;
      stop  = 1'b0;
      tx_st_out.ready = 1'b1;
      chk($sformatf("v%0d finished_in_budget", idx), fin, 1'b1);
      chk($sformatf("v%0d frames", idx), fr, tv.exp_frames);
      chk($sformatf("v%0d sent_pkts", idx), sent_pkts, tv.exp_frames);
      chk($sformatf("v%0d stall_cycles", idx), stall_cycles, tv.exp_stall);
      chk($sformatf("v%0d busy_at_done", idx), busy, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d done_one_cycle", idx), done, 1'b0);
      if (!fin) begin
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
      end
   endtask

   initial begin
      //        len     num  gap bp stop err | L   beats empty frames stall
      vecs[0] = '{14'd64,    1, 0, 0, 0, 0,   64,    8, 3'd0, 1,  0};
      vecs[1] = '{14'd70,    1, 0, 0, 0, 0,   70,    9, 3'd2, 1,  0};
      vecs[2] = '{14'd128,   1, 0, 1, 0, 0,   128,  16, 3'd0, 1, 30};
      vecs[3] = '{14'd66,    3, 5, 0, 0, 0,   66,    9, 3'd6, 3,  0};
      vecs[4] = '{14'd10,    2, 0, 0, 0, 0,   64,    8, 3'd0, 2,  0};
      vecs[5] = '{14'd12000, 1, 0, 0, 0, 0,   9600, 1200, 3'd0, 1, 0};
      vecs[6] = '{14'd65,    2, 1, 0, 0, 0,   65,    9, 3'd7, 2,  0};
      vecs[7] = '{14'd64,    0, 2, 0, 4, 0,   64,    8, 3'd0, 4,  0};
      vecs[8] = '{14'd64,    4, 0, 0, 0, 2,   64,    8, 3'd0, 4,  0};

      rst_n = 1'b0; start = 1'b0; stop = 1'b0;
      cfg_len = '0; cfg_num_pkts = '0; cfg_gap = '0;
      cfg_dst_mac = '0; cfg_src_mac = '0; err_every = '0;
      tx_st_out.ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset valid", tx_st_out.valid, 1'b0);
      chk("reset ctl", {tx_st_out.startofpacket, tx_st_out.endofpacket,
                        tx_st_out.empty, tx_st_out.error}, 6'd0);
      chk("reset data", tx_st_out.data, 64'd0);
      chk("reset status", {busy, done}, 2'd0);
      chk("reset counters", {sent_pkts, stall_cycles}, 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // Stop while in GAP goes straight to IDLE
      begin
         bit seen = 0;
         @(negedge clk);
         cfg_len = 14'd64; cfg_num_pkts = 32'd0; cfg_gap = 8'd10;
         cfg_dst_mac = c_dst; cfg_src_mac = c_src; start = 1'b1;
         for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            seen = tx_st_out.valid && tx_st_out.endofpacket;
         end
         chk("gapstop eop_seen", seen, 1'b1);
         repeat (3) @(negedge clk);
         chk("gapstop in_gap", {busy, tx_st_out.valid}, 2'b10);
         stop = 1'b1;
         @(negedge clk);
         stop = 1'b0;
         chk("gapstop idle", {busy, done, tx_st_out.valid}, 3'b010);
         chk("gapstop sent", sent_pkts, 32'd1);
         @(negedge clk);
         chk("gapstop done_pulse", done, 1'b0);
      end

      // Reset mid-frame
      @(negedge clk);
      cfg_len = 14'd64; cfg_num_pkts = 32'd1; cfg_gap = 8'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst running", tx_st_out.valid, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst valid_busy", {tx_st_out.valid, busy, done}, 3'b000);
      chk("midrst sent", sent_pkts, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst stays_idle", {tx_st_out.valid, busy}, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
